// File: rtl/cond_logic.sv
// cond_logic: NZCV flag register, ARM condition decode and multi-cycle issue/stall FSM
module cond_logic #(
    parameter int COND_W = 4,
    parameter int FLAG_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [COND_W-1:0] Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    input  logic              MStart,
    input  logic              Busy,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              Start,
    output logic              Stall,
    output logic              CarryFlag,
    output logic [FLAG_W-1:0] Flags
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cond_lat_q, cond_lat_d;
    logic              cond_ex;
    logic              upd;

    // Condition decode from the registered flags only
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = flags_q[3] == flags_q[0];
            4'b1011: cond_ex = flags_q[3] != flags_q[0];
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Next state, write gating and flag update; completion uses the condition latched at issue
    always_comb begin
        state_d    = state_q;
        cond_lat_d = cond_lat_q;
        flags_d    = flags_q;
        PCSrc      = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Start      = 1'b0;
        Stall      = 1'b0;
        upd        = 1'b0;
        if (state_q == S_IDLE) begin
            PCSrc    = PCS & cond_ex;
            MemWrite = MemW & cond_ex;
            RegWrite = RegW & cond_ex & ~NoWrite & ~MStart;
            Start    = MStart & cond_ex;
            upd      = cond_ex;
            if (MStart & cond_ex) begin
                state_d    = S_WAIT;
                cond_lat_d = 1'b1;
            end
        end else begin
            Stall = Busy;
            if (!Busy) begin
                RegWrite   = RegW & ~NoWrite & cond_lat_q;
                upd        = cond_lat_q;
                state_d    = S_IDLE;
                cond_lat_d = 1'b0;
            end
        end
        if (upd && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
        if (upd && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end

    // State, latched condition and flag registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cond_lat_q <= 1'b0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            cond_lat_q <= cond_lat_d;
            flags_q    <= flags_d;
        end
    end

    assign CarryFlag = flags_q[1];
    assign Flags     = flags_q;
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed vector table plus randomized run against a reference model
module tb_cond_logic;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] Cond = '0, ALUFlags = '0, Flags;
    logic [1:0] FlagW = '0;
    logic       PCS = 0, RegW = 0, MemW = 0, NoWrite = 0, MStart = 0, Busy = 0;
    logic       PCSrc, RegWrite, MemWrite, Start, Stall, CarryFlag;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pcs, regw, memw, nw, ms, busy;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];

    cond_logic dut (
        .CLK(CLK), .RESET(RESET), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .MStart(MStart),
        .Busy(Busy), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Start(Start), .Stall(Stall), .CarryFlag(CarryFlag), .Flags(Flags)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic rst, input logic [3:0] cond, input logic [3:0] alu,
                                input logic [1:0] fw, input logic pcs, input logic regw,
                                input logic memw, input logic nw, input logic ms,
                                input logic busy, input logic [9:0] exp);
        vec_t t;
        t.rst = rst; t.cond = cond; t.alu = alu; t.fw = fw; t.pcs = pcs; t.regw = regw;
        t.memw = memw; t.nw = nw; t.ms = ms; t.busy = busy; t.exp = exp;
        return t;
    endfunction

    // Condition as "base predicate of Cond[3:1], inverted by Cond[0]"; 1111 never passes
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic [7:0] base;
        {n, z, cy, v} = f;
        base = {1'b1, ~z & (n == v), n == v, cy & ~z, v, n, cy, z};
        return (c == 4'hF) ? 1'b0 : base[c[3:1]] ^ c[0];
    endfunction

    task automatic drive(input vec_t t);
        @(negedge CLK);
        RESET = t.rst; Cond = t.cond; ALUFlags = t.alu; FlagW = t.fw; PCS = t.pcs;
        RegW = t.regw; MemW = t.memw; NoWrite = t.nw; MStart = t.ms; Busy = t.busy;
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = {PCSrc, RegWrite, MemWrite, Start, Stall, CarryFlag, Flags};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got={PCSrc,RegWrite,MemWrite,Start,Stall,C,NZCV}=%b expected=%b",
                     name, got, exp);
        end
    endtask

    initial begin
        logic [3:0] mf;
        logic       mwait, mlat, ce, upd;
        logic [9:0] e;
        vec_t       r;
        // directed sequence: each row's exp is the pre-edge output for that cycle
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 10'b00000_0_0000));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 10'b01000_0_0000));
        tbl.push_back(mk(0, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1, 0, 0, 10'b00000_0_0000));
        tbl.push_back(mk(0, 4'b0001, 4'b1000, 2'b11, 0, 1, 0, 0, 0, 0, 10'b00000_0_0100));
        tbl.push_back(mk(0, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0, 10'b00000_0_0100));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 10'b10000_0_1001));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 10'b10000_0_1001));
        tbl.push_back(mk(0, 4'b1011, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 10'b00000_0_1001));
        tbl.push_back(mk(0, 4'b1101, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 10'b00000_0_1001));
        tbl.push_back(mk(0, 4'b1110, 4'b0010, 2'b11, 0, 0, 0, 0, 0, 0, 10'b00000_0_1001));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0, 10'b00100_1_0010));
        tbl.push_back(mk(0, 4'b1001, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0, 10'b00000_1_0010));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0, 10'b00000_1_0010));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 10'b00000_1_0010));
        tbl.push_back(mk(0, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 0, 0, 10'b00000_0_0000));
        tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 10'b00000_0_1100));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0, 10'b00000_0_1100));
        tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0, 10'b00010_0_1100));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 0, 1, 10'b00001_0_1100));
        tbl.push_back(mk(0, 4'b1111, 4'b0011, 2'b01, 0, 1, 0, 0, 0, 0, 10'b01000_0_1100));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 10'b00000_1_1111));
        tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 10'b00010_1_1111));
        tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 1, 10'b00001_1_1111));
        tbl.push_back(mk(1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 1, 10'b00001_1_1111));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 10'b00000_0_0000));
        tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0, 10'b00010_0_0000));
        tbl.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 10'b01000_0_0000));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 10'b00000_0_0000));

        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", 10'b00000_0_0000);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            check($sformatf("row%0d", i), tbl[i].exp);
        end

        // randomized run; the table leaves the DUT idle with all flags clear
        mf = 4'b0000; mwait = 1'b0; mlat = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            r = mk($urandom_range(0, 49) == 0, 4'($urandom), 4'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3) == 0, 1'($urandom), 10'b0);
            drive(r);
            ce = cond_pass(r.cond, mf);
            if (!mwait) begin
                e[9:5] = {r.pcs & ce, r.regw & ce & ~r.nw & ~r.ms, r.memw & ce, r.ms & ce, 1'b0};
                upd = ce;
            end else begin
                e[9:5] = {1'b0, ~r.busy & r.regw & ~r.nw & mlat, 1'b0, 1'b0, r.busy};
                upd = ~r.busy & mlat;
            end
            e[4:0] = {mf[1], mf};
            check($sformatf("rand%0d", k), e);
            if (r.rst) begin
                mf = 4'b0000; mwait = 1'b0; mlat = 1'b0;
            end else begin
                if (upd && r.fw[1]) mf[3:2] = r.alu[3:2];
                if (upd && r.fw[0]) mf[1:0] = r.alu[1:0];
                if (!mwait && r.ms && ce) begin
                    mwait = 1'b1; mlat = 1'b1;
                end else if (mwait && !r.busy) begin
                    mwait = 1'b0; mlat = 1'b0;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
